// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RISC-V instruction fetch stage with one-entry stall buffer and redirect flush
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_id,
    output logic [31:0] instruccion_id,
    output logic [6:0]  opcode_id,
    output logic        valid_id
);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;
    logic        ifid_free;
    logic [31:0] redirect_target;

    assign ifid_free       = !valid_id || !stall;
    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign opcode_id       = instruccion_id[6:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    // A redirect with a request still in flight must swallow that response in DROP.
    always_comb begin
        state_next = state;
        case (state)
            WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? WAIT : DROP;
                end else if (imem_rvalid && !ifid_free) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_next = WAIT;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_next = WAIT;
                end
            end
            default: state_next = WAIT;
        endcase
    end

    always_comb begin
        imem_req  = (state == WAIT) && !rst;
        imem_addr = pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            pc_id          <= '0;
            instruccion_id <= NOP;
            valid_id       <= 1'b0;
            buf_pc         <= '0;
            buf_instr      <= NOP;
        end else if (redirect) begin
            pc             <= redirect_target;
            valid_id       <= 1'b0;
            instruccion_id <= NOP;
            buf_pc         <= '0;
            buf_instr      <= NOP;
        end else begin
            case (state)
                WAIT: begin
                    if (imem_rvalid) begin
                        pc <= pc + 32'd4;
                        if (ifid_free) begin
                            pc_id          <= pc;
                            instruccion_id <= imem_rdata;
                            valid_id       <= 1'b1;
                        end else begin
                            buf_pc    <= pc;
                            buf_instr <= imem_rdata;
                        end
                    end else if (ifid_free) begin
                        valid_id       <= 1'b0;
                        instruccion_id <= NOP;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_id          <= buf_pc;
                        instruccion_id <= buf_instr;
                        valid_id       <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a variable-latency memory model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc_id;
    logic [31:0] instruccion_id;
    logic [6:0]  opcode_id;
    logic        valid_id;

    int tests = 0;
    int errors = 0;
    int wait_cycles = 0;
    int cyc = 0;
    bit spacing_on = 1'b0;
    bit prev_seen = 1'b0;
    int prev_cyc = 0;

    logic        m_pending;
    logic [31:0] m_addr;
    int          m_cnt;

    logic [31:0] sb_q[$];

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .pc_id          (pc_id),
        .instruccion_id (instruccion_id),
        .opcode_id      (opcode_id),
        .valid_id       (valid_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory answers wait_cycles cycles after the request is first seen; 0 means same cycle.
    always_comb begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (m_pending) begin
            if (m_cnt >= wait_cycles) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(m_addr);
            end
        end else if (imem_req && wait_cycles == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(imem_addr);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending <= 1'b0;
            m_addr    <= '0;
            m_cnt     <= 0;
        end else if (imem_rvalid) begin
            m_pending <= 1'b0;
            m_cnt     <= 0;
        end else if (m_pending) begin
            m_cnt <= m_cnt + 1;
        end else if (imem_req) begin
            m_pending <= 1'b1;
            m_addr    <= imem_addr;
            m_cnt     <= 1;
        end
    end

    // Decode consumes IF/ID on the next edge when valid_id && !stall && !redirect.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (m_pending && imem_req) begin
                check("addr_stable", imem_addr, m_addr);
            end
            if (valid_id && !stall && !redirect) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    logic [31:0] exp_pc;
                    exp_pc = sb_q.pop_front();
                    check("sb_pc", pc_id, exp_pc);
                    check("sb_instr", instruccion_id, mem_word(exp_pc));
                    check("sb_opcode", 32'(opcode_id), 32'(mem_word(exp_pc) & 32'h7F));
                end
                if (spacing_on) begin
                    if (prev_seen) begin
                        check("spacing", 32'(cyc - prev_cyc), 32'd3);
                    end
                    prev_seen = 1'b1;
                    prev_cyc  = cyc;
                end else begin
                    prev_seen = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        stall = 1'b1;
    endtask

    task automatic settle();
        repeat (6) tick();
    endtask

    task automatic push_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(base + 32'(4 * i));
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        look();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(valid_id), 32'd0);
        check("rst_instr", instruccion_id, 32'h0000_0013);
        check("rst_pc_id", pc_id, 32'd0);
        check("rst_opcode", 32'(opcode_id), 32'h13);

        // Zero-wait streaming from RESET_PC
        tick();
        rst = 1'b0;
        push_run(32'h0, 8);
        for (int i = 0; i < 4; i++) begin
            look();
            check("seq_req", 32'(imem_req), 32'd1);
            check("seq_addr", imem_addr, 32'(4 * i));
            if (i > 0) begin
                check("seq_pc_id", pc_id, 32'(4 * (i - 1)));
                check("seq_valid", 32'(valid_id), 32'd1);
            end
            tick();
        end
        drain();
        settle();

        // Three-cycle memory: one instruction every 3 cycles
        wait_cycles = 2;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        stall = 1'b0;
        spacing_on = 1'b1;
        push_run(32'h200, 6);
        tick();
        redirect = 1'b0;
        drain();
        spacing_on = 1'b0;
        settle();

        // Stall with a response arriving: HOLD, then recovery
        wait_cycles = 0;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        stall = 1'b0;
        push_run(32'h0, 2);
        tick();
        redirect = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        tick();
        look();
        check("hold_pc_id", pc_id, 32'h4);
        check("hold_valid", 32'(valid_id), 32'd1);
        check("hold_state", 32'(dut.state), 32'd1);
        check("hold_req", 32'(imem_req), 32'd0);
        tick();
        look();
        check("hold2_pc_id", pc_id, 32'h4);
        check("hold2_req", 32'(imem_req), 32'd0);
        tick();
        stall = 1'b0;
        push_run(32'h8, 2);
        tick();
        look();
        check("rec_pc_id", pc_id, 32'h8);
        check("rec_req", 32'(imem_req), 32'd1);
        check("rec_addr", imem_addr, 32'hC);
        drain();
        settle();

        // Redirect to 0x103 with a slow request outstanding
        wait_cycles = 2;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        stall = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        stall = 1'b1;
        look();
        check("pre_pc_id", pc_id, 32'h40);
        check("pre_valid", 32'(valid_id), 32'd1);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        push_run(32'h100, 3);
        look();
        check("flush_valid", 32'(valid_id), 32'd0);
        check("flush_instr", instruccion_id, 32'h0000_0013);
        check("drop_req", 32'(imem_req), 32'd0);
        tick();
        look();
        check("tgt_addr", imem_addr, 32'h100);
        check("tgt_req", 32'(imem_req), 32'd1);
        drain();
        settle();

        // Redirect together with stall while in HOLD
        wait_cycles = 0;
        check("pre_hold_state", 32'(dut.state), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        look();
        check("rs_valid", 32'(valid_id), 32'd0);
        check("rs_instr", instruccion_id, 32'h0000_0013);
        check("rs_state", 32'(dut.state), 32'd0);
        check("rs_addr", imem_addr, 32'h300);
        tick();
        stall = 1'b0;
        push_run(32'h300, 2);
        drain();
        settle();

        // PC wrap
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        stall = 1'b0;
        sb_q.push_back(32'hFFFF_FFFC);
        push_run(32'h0, 2);
        tick();
        redirect = 1'b0;
        look();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        look();
        check("wrap_addr1", imem_addr, 32'h0);
        drain();
        settle();

        // Asynchronous reset mid-request
        wait_cycles = 2;
        redirect = 1'b1;
        redirect_pc = 32'h80;
        stall = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        stall = 1'b1;
        look();
        check("ar_pre_valid", 32'(valid_id), 32'd1);
        check("ar_pre_req", 32'(imem_req), 32'd1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("ar_req", 32'(imem_req), 32'd0);
        check("ar_valid", 32'(valid_id), 32'd0);
        check("ar_instr", instruccion_id, 32'h0000_0013);
        check("ar_pc_id", pc_id, 32'd0);
        stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        look();
        check("ar_rel_req", 32'(imem_req), 32'd1);
        check("ar_rel_addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
